// File: rtl/hex_display_pkg.sv
// Shared constants for the hex seven-segment scanner: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the scan FSM state encoding.
package hex_display_pkg;

  typedef enum logic {
    StBlank = 1'b0,
    StDrive = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/hex_display_scanner_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed common-anode hex display scanner with per-frame value snapshot.
// Define HEX_SCANNER_LZB_EN to blank leading zero digits (digit 0 always shown).
module hex_display_scanner #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned DIV_MAX      = 49999,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [WIDTH-1:0]        value_i,
  output logic [6:0]              seg_o,
  output logic [(WIDTH>>2)-1:0]   an_o,
  output logic                    frame_o
);

  import hex_display_pkg::*;

  localparam int unsigned NumDigits = WIDTH >> 2;
  localparam int unsigned IdxW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int unsigned CntMax    = (DIV_MAX > BLANK_CYCLES - 1) ? DIV_MAX : BLANK_CYCLES - 1;
  localparam int unsigned CntW      = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(DIV_MAX);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NumDigits - 1);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]       snap_q, snap_d;
  logic [6:0]             seg_q, seg_d;
  logic [NumDigits-1:0]   an_q, an_d;
  logic                   frame_q, frame_d;

  logic [3:0]             nibble;
  logic [6:0]             seg_dec;
  logic                   lzb_blank;

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StBlank;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    snap_d  = snap_q;
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StDrive;
          cnt_d   = '0;
          if (idx_q == '0) begin
            snap_d = value_i;
          end
        end
      end
      StDrive: begin
        if (cnt_q == DriveLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
      end
    endcase
  end

  // Nibble mux on next-state values so registered outputs line up with the state.
  always_comb begin
    nibble = '0;
    for (int unsigned i = 0; i < NumDigits; i++) begin
      if (IdxW'(i) == idx_d) begin
        nibble = snap_d[4*i +: 4];
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

`ifdef HEX_SCANNER_LZB_EN
  logic upper_zero;

  // True when the current digit and every more significant digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NumDigits; i++) begin
      if ((IdxW'(i) >= idx_d) && (snap_d[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  assign lzb_blank = (idx_d != '0) && upper_zero;
`else
  assign lzb_blank = 1'b0;
`endif

  // Output logic
  always_comb begin
    seg_d   = SEG_BLANK;
    an_d    = '1;
    frame_d = (state_q == StBlank) && (state_d == StDrive) && (idx_q == '0);
    if (state_d == StDrive) begin
      for (int unsigned i = 0; i < NumDigits; i++) begin
        an_d[i] = (IdxW'(i) != idx_d);
      end
      seg_d = lzb_blank ? SEG_BLANK : seg_dec;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (WIDTH=8, DIV_MAX=3, BLANK_CYCLES=2).
module tb_hex_display_scanner;

  localparam int Frame = 12;

  logic       clk;
  logic       reset_ni;
  logic [7:0] value_i;
  logic [6:0] seg_o;
  logic [1:0] an_o;
  logic       frame_o;

  int total = 0;
  int bad   = 0;

  int         k;
  logic [7:0] snap_m;
  logic [6:0] seg_tab [16];

  hex_display_scanner #(
    .WIDTH        (8),
    .DIV_MAX      (3),
    .BLANK_CYCLES (2)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .value_i  (value_i),
    .seg_o    (seg_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"}, 32'(an_o), 32'h3);
    check({tag, "_seg"}, 32'(seg_o), 32'h7F);
    check({tag, "_frame"}, 32'(frame_o), 32'h0);
  endtask

  // Timeline after reset release: edge 1 blank, then from edge 2 a 12-cycle frame:
  // slots 0..3 digit 0, 4..5 gap, 6..9 digit 1, 10..11 gap.
  task automatic step();
    int         slot;
    int         digit;
    logic [3:0] nib;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    @(posedge clk);
    k++;
    slot = (k < 2) ? -1 : (k - 2) % Frame;
    if (slot == 0) snap_m = value_i;
    #1;
    if (slot >= 0 && slot <= 3) digit = 0;
    else if (slot >= 6 && slot <= 9) digit = 1;
    else digit = -1;
    exp_an  = 2'b11;
    exp_seg = 7'h7F;
    if (digit >= 0) begin
      nib     = (digit == 1) ? snap_m[7:4] : snap_m[3:0];
      exp_an  = (digit == 1) ? 2'b01 : 2'b10;
      exp_seg = seg_tab[nib];
`ifdef HEX_SCANNER_LZB_EN
      if (digit == 1 && snap_m[7:4] == 4'h0) exp_seg = 7'h7F;
`endif
    end
    check("an", 32'(an_o), 32'(exp_an));
    check("seg", 32'(seg_o), 32'(exp_seg));
    check("frame", 32'(frame_o), 32'(slot == 0));
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_ni = 1'b1;
    k        = 0;
    snap_m   = 8'h00;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    k       = 0;
    snap_m  = 8'h00;
    value_i = 8'hA1;
    reset_ni = 1'b1;
    #1 reset_ni = 1'b0;
    #1 check_blank("reset_async");
    repeat (3) @(posedge clk);
    #1 check_blank("reset_held");

    // Frames of A1, then switch to 5F while digit 1 is on screen.
    release_reset();
    repeat (8) step();
    value_i = 8'h5F;
    repeat (22) step();

    // Asynchronous reset mid-DRIVE, between clock edges.
    value_i = 8'hA1;
    while (((k - 2) % Frame) != 1) step();
    #2 reset_ni = 1'b0;
    #1 check_blank("reset_mid_drive");
    repeat (2) @(posedge clk);
    #1 check_blank("reset_mid_held");
    release_reset();
    repeat (14) step();

    // Leading-zero cases.
    value_i = 8'h07;
    repeat (Frame) step();
    value_i = 8'h00;
    repeat (Frame) step();
    value_i = 8'h30;
    repeat (Frame) step();

    // Counter-driven sweep: value advances every cycle, one snapshot per frame.
    value_i = 8'h00;
    repeat (256 * 2) begin
      step();
      value_i = value_i + 8'h01;
    end

    // Random values changing at random times.
    repeat (400) begin
      step();
      if ($urandom_range(0, 3) == 0) value_i = 8'($urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
